// File: rtl/sync_generator.sv
// Raster timing generator: a pixel-phase divider, horizontal/vertical
// position counters, and one four-region FSM per axis. The FSMs drive the
// display-enable and sync outputs. All outputs are registered and update
// together with the counters, so downstream logic sees a consistent
// position and decode whenever pc_ena reads 0.
//
// state  | meaning
// ACTIVE | visible pixels (h < H_RES) / visible lines (v < V_RES)
// FRONT  | front porch
// SYNC   | sync pulse, hs / vs asserted
// BACK   | back porch; also the reset state, so the first advance opens a frame
module sync_generator #(
    parameter int H_RES   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_RES   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int PIX_DIV = 3
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        run,
    output logic [3:0]  pc_ena,
    output logic [11:0] h_count,
    output logic [11:0] v_count,
    output logic        hde,
    output logic        vde,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // Last column or line of each region. An FSM leaves a region on the
    // advance that moves the counter past that value.
    localparam logic [11:0] H_ACT_LAST  = 12'(H_RES - 1);
    localparam logic [11:0] H_FP_LAST   = 12'(H_RES + H_FP - 1);
    localparam logic [11:0] H_SYNC_LAST = 12'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);

    localparam logic [11:0] V_ACT_LAST  = 12'(V_RES - 1);
    localparam logic [11:0] V_FP_LAST   = 12'(V_RES + V_FP - 1);
    localparam logic [11:0] V_SYNC_LAST = 12'(V_RES + V_FP + V_SYNC - 1);
    localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);

    localparam logic [3:0]  PC_LAST     = 4'(PIX_DIV);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } region_t;

    logic [3:0]  r_pc;
    logic [11:0] r_h;
    logic [11:0] r_v;
    region_t     r_h_state;
    region_t     r_v_state;
    logic        r_hde;
    logic        r_hs;
    logic        r_vde;
    logic        r_vs;
    logic        r_line_start;
    logic        r_frame_start;

    logic        w_adv;
    logic        w_h_wrap;
    logic        w_v_wrap;

    // A pixel advance happens on the last phase of a pixel. When run is low
    // on that cycle, no advance happens.
    assign w_adv    = run && (r_pc == PC_LAST);
    assign w_h_wrap = w_adv && (r_h == H_LAST);
    assign w_v_wrap = w_h_wrap && (r_v == V_LAST);

    // Pixel phase divider: counts 0..PIX_DIV. It stays at 0 when PIX_DIV is 0.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_pc <= 4'd0;
        end else if (run) begin
            if (r_pc == PC_LAST) begin
                r_pc <= 4'd0;
            end else begin
                r_pc <= r_pc + 4'd1;
            end
        end
    end

    // Column counter. It starts on the last column so the first advance lands on 0.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_h <= H_LAST;
        end else if (w_adv) begin
            if (r_h == H_LAST) begin
                r_h <= 12'd0;
            end else begin
                r_h <= r_h + 12'd1;
            end
        end
    end

    // Line counter. It steps once per line wrap and starts on the last line.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_v <= V_LAST;
        end else if (w_h_wrap) begin
            if (r_v == V_LAST) begin
                r_v <= 12'd0;
            end else begin
                r_v <= r_v + 12'd1;
            end
        end
    end

    // Horizontal region FSM with registered hde/hs. These outputs are updated
    // on the same edge as the column counter.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_h_state <= BACK;
            r_hde     <= 1'b0;
            r_hs      <= 1'b0;
        end else if (w_adv) begin
            case (r_h_state)
                ACTIVE: begin
                    if (r_h == H_ACT_LAST) begin
                        r_h_state <= FRONT;
                        r_hde     <= 1'b0;
                    end
                end
                FRONT: begin
                    if (r_h == H_FP_LAST) begin
                        r_h_state <= SYNC;
                        r_hs      <= 1'b1;
                    end
                end
                SYNC: begin
                    if (r_h == H_SYNC_LAST) begin
                        r_h_state <= BACK;
                        r_hs      <= 1'b0;
                    end
                end
                BACK: begin
                    if (r_h == H_LAST) begin
                        r_h_state <= ACTIVE;
                        r_hde     <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Vertical region FSM. It has the same structure as the horizontal one
    // and is stepped on each line wrap.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_v_state <= BACK;
            r_vde     <= 1'b0;
            r_vs      <= 1'b0;
        end else if (w_h_wrap) begin
            case (r_v_state)
                ACTIVE: begin
                    if (r_v == V_ACT_LAST) begin
                        r_v_state <= FRONT;
                        r_vde     <= 1'b0;
                    end
                end
                FRONT: begin
                    if (r_v == V_FP_LAST) begin
                        r_v_state <= SYNC;
                        r_vs      <= 1'b1;
                    end
                end
                SYNC: begin
                    if (r_v == V_SYNC_LAST) begin
                        r_v_state <= BACK;
                        r_vs      <= 1'b0;
                    end
                end
                BACK: begin
                    if (r_v == V_LAST) begin
                        r_v_state <= ACTIVE;
                        r_vde     <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Line and frame strobes. Each one is high for a single pclk, on the
    // cycle where the counters show the new origin.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign pc_ena      = r_pc;
    assign h_count     = r_h;
    assign v_count     = r_v;
    assign hde         = r_hde;
    assign vde         = r_vde;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sync_generator.sv
// Bench for sync_generator. It runs two builds of the same small raster:
// build A with four pclk per pixel, and build B with one pclk per pixel.
// A behavioural model pushes the expected outputs for each cycle to a
// queue. The entries are popped and compared after the edge.
module tb_sync_generator;

    logic        pclk;
    logic        reset;
    logic        run;

    logic [3:0]  pc_a, pc_b;
    logic [11:0] h_a, v_a, h_b, v_b;
    logic        hde_a, vde_a, hs_a, vs_a, ls_a, fs_a;
    logic        hde_b, vde_b, hs_b, vs_b, ls_b, fs_b;

    typedef struct packed {
        logic [3:0]  pc;
        logic [11:0] h;
        logic [11:0] v;
        logic        hde;
        logic        vde;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    obs_t q_exp[$];

    int n_checks;
    int n_fail;
    int cyc;
    int m_pc[2];
    int m_h[2];
    int m_v[2];
    bit m_ls[2];
    bit m_fs[2];
    int last_ls[2];
    int last_fs[2];

    sync_generator #(
        .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(3)
    ) u_dut_a (
        .pclk(pclk), .reset(reset), .run(run),
        .pc_ena(pc_a), .h_count(h_a), .v_count(v_a),
        .hde(hde_a), .vde(vde_a), .hs(hs_a), .vs(vs_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    sync_generator #(
        .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(0)
    ) u_dut_b (
        .pclk(pclk), .reset(reset), .run(run),
        .pc_ena(pc_b), .h_count(h_b), .v_count(v_b),
        .hde(hde_b), .vde(vde_b), .hs(hs_b), .vs(vs_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Reference raster: H_TOTAL=8 (active 0..3, sync 5..6) and V_TOTAL=6
    // (active 0..2, sync 4).
    task automatic model_step(input int id, input int pd, input bit rst, input bit rn);
        obs_t e;
        m_ls[id] = 1'b0;
        m_fs[id] = 1'b0;
        if (rst) begin
            m_pc[id] = 0;
            m_h[id]  = 7;
            m_v[id]  = 5;
        end else if (rn) begin
            if (m_pc[id] == pd) begin
                m_pc[id] = 0;
                m_h[id]  = m_h[id] + 1;
                if (m_h[id] == 8) begin
                    m_h[id]  = 0;
                    m_ls[id] = 1'b1;
                    m_v[id]  = m_v[id] + 1;
                    if (m_v[id] == 6) begin
                        m_v[id]  = 0;
                        m_fs[id] = 1'b1;
                    end
                end
            end else begin
                m_pc[id] = m_pc[id] + 1;
            end
        end
        e.pc  = 4'(m_pc[id]);
        e.h   = 12'(m_h[id]);
        e.v   = 12'(m_v[id]);
        e.hde = (m_h[id] < 4);
        e.hs  = (m_h[id] == 5) || (m_h[id] == 6);
        e.vde = (m_v[id] < 3);
        e.vs  = (m_v[id] == 4);
        e.ls  = m_ls[id];
        e.fs  = m_fs[id];
        q_exp.push_back(e);
    endtask

    task automatic compare(input int id, input string nm, input obs_t o, input int line_per,
                           input int frame_per);
        obs_t e;
        if (q_exp.size() == 0) begin
            chk({nm, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = q_exp.pop_front();
        chk({nm, "_pc_ena"},      32'(o.pc),  32'(e.pc));
        chk({nm, "_h_count"},     32'(o.h),   32'(e.h));
        chk({nm, "_v_count"},     32'(o.v),   32'(e.v));
        chk({nm, "_hde"},         32'(o.hde), 32'(e.hde));
        chk({nm, "_vde"},         32'(o.vde), 32'(e.vde));
        chk({nm, "_hs"},          32'(o.hs),  32'(e.hs));
        chk({nm, "_vs"},          32'(o.vs),  32'(e.vs));
        chk({nm, "_line_start"},  32'(o.ls),  32'(e.ls));
        chk({nm, "_frame_start"}, 32'(o.fs),  32'(e.fs));
        if (o.ls) begin
            if (last_ls[id] >= 0) chk({nm, "_line_period"}, 32'(cyc - last_ls[id]), 32'(line_per));
            last_ls[id] = cyc;
        end
        if (o.fs) begin
            if (last_fs[id] >= 0) chk({nm, "_frame_period"}, 32'(cyc - last_fs[id]), 32'(frame_per));
            last_fs[id] = cyc;
        end
    endtask

    task automatic step(input bit rst, input bit rn);
        obs_t oa, ob;
        @(negedge pclk);
        reset = rst;
        run   = rn;
        if (rst || !rn) begin
            for (int i = 0; i < 2; i++) begin
                last_ls[i] = -1;
                last_fs[i] = -1;
            end
        end
        model_step(0, 3, rst, rn);
        model_step(1, 0, rst, rn);
        @(posedge pclk);
        #1;
        cyc++;
        oa = '{pc: pc_a, h: h_a, v: v_a, hde: hde_a, vde: vde_a, hs: hs_a, vs: vs_a,
               ls: ls_a, fs: fs_a};
        ob = '{pc: pc_b, h: h_b, v: v_b, hde: hde_b, vde: vde_b, hs: hs_b, vs: vs_b,
               ls: ls_b, fs: fs_b};
        compare(0, "a", oa, 32, 192);
        compare(1, "b", ob, 8, 48);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        run      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_ls[i] = -1;
            last_fs[i] = -1;
        end

        // Reset state, then continuous running across two full frames.
        repeat (3) step(1'b1, 1'b1);
        repeat (420) step(1'b0, 1'b1);

        // Freeze mid-line at h=2 with pc_ena=1 on build A.
        n = 0;
        while (!(m_h[0] == 2 && m_pc[0] == 1) && n < 200) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("seek_h2_in_budget", 32'(n < 200), 32'd1);
        repeat (5) step(1'b0, 1'b0);
        repeat (40) step(1'b0, 1'b1);

        // Reset in the middle of a frame at h=5, v=1.
        n = 0;
        while (!(m_h[0] == 5 && m_v[0] == 1) && n < 400) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("seek_h5v1_in_budget", 32'(n < 400), 32'd1);
        step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);

        // Random run gating, with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0));
        end
        repeat (200) step(1'b0, 1'b1);

        chk("queue_drained", 32'(q_exp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_generator.md
SYNC_GENERATOR -- requirements
Module: sync_generator

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, meaning horizontal front porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning horizontal sync pixels.
REQ-004 SHALL have parameter H_BP, default 48, meaning horizontal back porch pixels.
REQ-005 SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, meaning vertical front porch lines.
REQ-007 SHALL have parameter V_SYNC, default 2, meaning vertical sync lines.
REQ-008 SHALL have parameter V_BP, default 33, meaning vertical back porch lines.
REQ-009 SHALL have parameter PIX_DIV, default 3, meaning the pclk count per pixel minus one (0..15).
REQ-010 SHALL have port pclk, input, 1, the clock.
REQ-011 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-012 SHALL have port run, input, 1, advance enable; low freezes all state.
REQ-013 SHALL have port pc_ena, output, 4, pixel phase counter; value 0 marks the pixel-processing cycle for downstream stages.
REQ-014 SHALL have port h_count, output, 12, current pixel column.
REQ-015 SHALL have port v_count, output, 12, current line.
REQ-016 SHALL have ports hde, vde, hs, vs, output, 1 each: horizontal/vertical display enable and active-high syncs.
REQ-017 SHALL have ports line_start and frame_start, output, 1 each: single-pclk strobes.

Function
REQ-018 SHALL define H_TOTAL = H_RES+H_FP+H_SYNC+H_BP and V_TOTAL likewise; both SHALL be at most 4096, and every porch/sync parameter SHALL be at least 1.
REQ-019 SHALL, on each pclk with run=1, increment pc_ena, wrapping from PIX_DIV to 0; PIX_DIV=0 SHALL hold pc_ena at 0.
REQ-020 SHALL advance the pixel position on the pclk where run=1 and pc_ena==PIX_DIV, so new h_count/v_count and decoded outputs are valid when pc_ena reads 0.
REQ-021 SHALL, on a pixel advance, increment h_count, wrapping H_TOTAL-1 -> 0; on that wrap v_count SHALL increment, wrapping V_TOTAL-1 -> 0.
REQ-022 SHALL track horizontal phase with FSM states ACTIVE (h<H_RES), FRONT, SYNC, BACK, transitioning only at region boundaries on pixel advance; the vertical phase SHALL use an identical four-state FSM stepped on h_count wrap.
REQ-023 SHALL register hde=1 exactly in horizontal ACTIVE, hs=1 exactly in horizontal SYNC; vde and vs likewise for vertical; these SHALL change in the same cycle as the counters (zero latency relative to h_count/v_count).
REQ-024 SHALL pulse line_start for one pclk in the cycle h_count becomes 0, and frame_start in the cycle h_count and v_count both become 0 (line_start also high then).
REQ-025 SHALL, with run=0, hold pc_ena, counters, FSM states and hde/vde/hs/vs unchanged, and drive line_start=frame_start=0.
REQ-026 SHALL give run deassertion on an advance cycle priority: no advance occurs.

Reset
REQ-027 SHALL, while reset=1, set pc_ena=0, h_count=H_TOTAL-1, v_count=V_TOTAL-1, both FSMs to BACK, hde=vde=hs=vs=0, line_start=frame_start=0.
REQ-028 SHALL take reset priority over run; reset mid-frame SHALL abandon the frame, and the first advance after release SHALL produce h_count=0, v_count=0 with frame_start=1.

Verification
(All scenarios use H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), PIX_DIV=3, run=1 unless stated.)
REQ-029 SHALL check: release reset -> pc_ena 0,1,2,3; on the 4th pclk h=0,v=0, hde=vde=1, frame_start=line_start=1 for one pclk.
REQ-030 SHALL check: run one full line -> hde=1 for h=0..3, hs=1 for h=5..6, line_start once per 32 pclk, v increments on h 7->0.
REQ-031 SHALL check: run one full frame -> vde=1 for v=0..2, vs=1 only for v=4, frame_start period 192 pclk, counters wrap (7,5)->(0,0).
REQ-032 SHALL check: run=0 for 5 pclk mid-line at h=2, pc_ena=1 -> all outputs frozen and strobes 0; resumes at pc_ena=2 with no skipped pixel.
REQ-033 SHALL check: reset at h=5,v=1 -> next pclk h=7,v=5, hde=vde=hs=vs=0; the first advance after release gives frame_start.
REQ-034 SHALL check: rebuild with PIX_DIV=0 -> pc_ena stays 0, h_count advances every pclk, line period 8 pclk.
